wormhole_arbiter: RTL and testbench
===================================

WORMHOLE_ARBITER -- requirements
Module: wormhole_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of input circular buffers sharing one output link.
REQ-002 Parameter PTR_W, default $clog2(NUM_IN), width of the round-robin pointer.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 buf_empty_i  input  NUM_IN  per-buffer empty flag; bit k high = buffer k holds no flit.
REQ-006 flit_i  input  NUM_IN x flit_Data_noVC  head-of-buffer flit of each buffer; valid only while buf_empty_i[k] low.
REQ-007 down_on_i  input  1  downstream on/off; high = a flit may be sent this cycle.
REQ-008 read_o  output  NUM_IN  pop strobe to buffer k; the buffer removes its head flit at the same posedge.
REQ-009 flit_o  output  flit_Data_noVC  registered forwarded flit.
REQ-010 flit_valid_o  output  1  registered; high for exactly the cycle after a pop.
REQ-011 grant_o  output  NUM_IN  one-hot current owner; all zero when unlocked.
REQ-012 proto_err_o  output  1  one-cycle pulse on a packet-framing violation.

Function
REQ-013 FSM has two states: IDLE (no owner) and LOCKED (owner holds the link until its TAIL).
REQ-014 Request k = !buf_empty_i[k]; read_o is combinational from state, requests and down_on_i.
REQ-015 IDLE: when any request is present and down_on_i=1, the winner is the first requester found searching upward from rr_ptr with wrap at NUM_IN-1 -> 0; read_o[winner]=1 in that cycle.
REQ-016 IDLE: when no request is present or down_on_i=0, read_o=0 and state is unchanged.
REQ-017 IDLE pop of HEAD: next state LOCKED, owner=winner, grant_o one-hot on winner from the next cycle.
REQ-018 IDLE pop of HEADTAIL: state stays IDLE, rr_ptr=(winner+1) mod NUM_IN.
REQ-019 IDLE pop of BODY or TAIL: the flit is forwarded, proto_err_o pulses the next cycle, the flit is treated as a single-flit packet, and rr_ptr advances as in REQ-018.
REQ-020 LOCKED: read_o[owner]=!buf_empty_i[owner] && down_on_i; all other read_o bits are 0 regardless of their requests.
REQ-021 LOCKED pop of TAIL: next state IDLE, grant_o cleared, rr_ptr=(owner+1) mod NUM_IN.
REQ-022 LOCKED pop of HEAD or HEADTAIL: the flit is forwarded, proto_err_o pulses, state stays LOCKED.
REQ-023 LOCKED with owner empty or down_on_i=0: no pop; owner is held indefinitely (wormhole, no timeout).
REQ-024 Latency: flit_o=flit_i[popped] and flit_valid_o=1 one cycle after read_o; with no pop, flit_valid_o=0 and flit_o holds its value.
REQ-025 At most one read_o bit is high in any cycle; sustained throughput is one flit per cycle.
REQ-026 rr_ptr is PTR_W bits; the wrap uses an explicit compare against NUM_IN-1, not the binary overflow.

Reset
REQ-027 Assertion of rst_n (low), including mid-packet, immediately forces state=IDLE, owner=0, rr_ptr=0, flit_o='0, flit_valid_o=0, grant_o=0, proto_err_o=0.
REQ-028 read_o is 0 while rst_n is low.
REQ-029 The first arbitration after reset release starts from input 0.

Structure
REQ-030 flit_Data_noVC, flit label enum (HEAD/BODY/TAIL/HEADTAIL) and the arb_state_t enum {IDLE, LOCKED} reside in package params_noc.
REQ-031 Sub-module rr_arbiter (combinational; inputs req vector and rr_ptr; outputs one-hot gnt and index) implements the REQ-015 search.

Verification
REQ-032 NUM_IN=5, down_on_i=1; buffers 1 and 3 each hold a HEADTAIL; rr_ptr=0 -> read_o=00010, then 01000; flit_valid_o high for 2 consecutive cycles; final rr_ptr=4.
REQ-033 Buffer 2 holds HEAD,BODY,TAIL and buffer 0 holds a HEADTAIL -> buffer 2 is served first (rr_ptr=1); buffer 0 waits 3 cycles; then read_o=00001; rr_ptr=3 after buffer 2's TAIL.
REQ-034 Owner 2 is LOCKED and down_on_i=0 for 4 cycles -> read_o=0, flit_valid_o=0, grant_o=00100 throughout; the next flit is forwarded 1 cycle after down_on_i rises.
REQ-035 Buffer 4 head is a BODY in IDLE -> flit forwarded, proto_err_o=1 for 1 cycle, state stays IDLE, rr_ptr=0.
REQ-036 rst_n driven low after HEAD,BODY of buffer 1 -> outputs are at reset values asynchronously; after release, buffer 3's HEADTAIL is granted ahead of buffer 1's TAIL (proto_err_o pulses when that TAIL is later popped).
REQ-037 All 5 buffers continuously hold HEADTAILs -> grants rotate 0,1,2,3,4,0 with one flit per cycle.

Source files
------------

// File: rtl/params_noc.sv
// Shared NoC types for the wormhole output-link arbiter.
//   flit_label_t   : framing label carried by every flit
//   flit_Data_noVC : one flit without a virtual-channel field (label + payload)
//   arb_state_t    : link ownership state (IDLE = free, LOCKED = owned until TAIL)
package params_noc;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       label;
    logic [DATA_W-1:0] data;
  } flit_Data_noVC;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search.
//   req    : request vector, bit k = input k wants the link
//   rr_ptr : first index examined; the search walks upward and wraps NUM_IN-1 -> 0
//   gnt    : one-hot winner (all zero when nothing requests)
//   idx    : binary index of the winner (0 when nothing requests)
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [PTR_W-1:0]  idx
);

  always_comb begin
    logic [PTR_W-1:0] cand;
    logic             found;
    // NOTE: every output gets a default before any branch so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = rr_ptr;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
      // Wrap on an explicit compare: NUM_IN need not be a power of two.
      cand = (cand == PTR_W'(NUM_IN - 1)) ? '0 : cand + PTR_W'(1);
    end
  end

endmodule

// File: rtl/wormhole_arbiter.sv
// Wormhole arbiter: NUM_IN input circular buffers share one output link.
// A HEAD flit locks the link to its buffer until that buffer's TAIL passes;
// single-flit packets (HEADTAIL) never lock. Misframed flits are still
// forwarded but flag proto_err_o for one cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   buf_empty_i   : per-buffer empty flags (request = !empty)
//   flit_i        : head flit of each buffer
//   down_on_i     : downstream can accept a flit this cycle
//   read_o        : combinational pop strobe, at most one bit high
//   flit_o        : registered forwarded flit (holds when nothing is popped)
//   flit_valid_o  : high the cycle after a pop
//   grant_o       : one-hot owner while LOCKED, zero otherwise
//   proto_err_o   : one-cycle framing-violation pulse
module wormhole_arbiter
  import params_noc::*;
#(
  parameter int NUM_IN = 5,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NUM_IN-1:0] buf_empty_i,
  input  flit_Data_noVC flit_i [NUM_IN],
  input  logic          down_on_i,
  output logic [NUM_IN-1:0] read_o,
  output flit_Data_noVC flit_o,
  output logic          flit_valid_o,
  output logic [NUM_IN-1:0] grant_o,
  output logic          proto_err_o
);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  win_idx, pop_idx;
  logic [NUM_IN-1:0] req, win_gnt;
  logic              pop, err_d;
  flit_Data_noVC     pop_flit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_IN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req = ~buf_empty_i;

  rr_arbiter #(.NUM_IN(NUM_IN), .PTR_W(PTR_W)) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win_gnt),
    .idx    (win_idx)
  );

  // Pop selection. Gated by rst_n so no buffer is drained while reset is held.
  always_comb begin
    read_o  = '0;
    pop_idx = owner_q;
    if (rst_n && down_on_i) begin
      if (state_q == IDLE) begin
        read_o  = win_gnt;
        pop_idx = win_idx;
      end else begin
        read_o[owner_q] = req[owner_q];
      end
    end
  end

  assign pop      = |read_o;
  assign pop_flit = flit_i[pop_idx];

  // Next state: ownership, pointer advance and framing check.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = 1'b0;
    if (pop) begin
      unique case (state_q)
        IDLE: begin
          if (pop_flit.label == HEAD) begin
            state_d = LOCKED;
            owner_d = pop_idx;
          end else begin
            // HEADTAIL, or a stray BODY/TAIL closed as a one-flit packet.
            rr_ptr_d = next_ptr(pop_idx);
            err_d    = (pop_flit.label == BODY) || (pop_flit.label == TAIL);
          end
        end
        LOCKED: begin
          if (pop_flit.label == TAIL) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end else begin
            err_d = (pop_flit.label == HEAD) || (pop_flit.label == HEADTAIL);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
      proto_err_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      flit_valid_o <= pop;
      proto_err_o  <= err_d;
      if (pop) flit_o <= pop_flit;
    end
  end

  always_comb begin
    grant_o = '0;
    if (state_q == LOCKED) grant_o[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_wormhole_arbiter.sv
module tb_wormhole_arbiter;
  import params_noc::*;

  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  buf_empty;
  flit_Data_noVC flit_i [N];
  logic          down_on = 1'b1;
  logic [N-1:0]  read_o;
  flit_Data_noVC flit_o;
  logic          flit_valid_o;
  logic [N-1:0]  grant_o;
  logic          proto_err_o;

  wormhole_arbiter #(.NUM_IN(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buf_empty_i  (buf_empty),
    .flit_i       (flit_i),
    .down_on_i    (down_on),
    .read_o       (read_o),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .grant_o      (grant_o),
    .proto_err_o  (proto_err_o)
  );

  always #5 clk = ~clk;

  // Buffer contents and observed pop order.
  flit_Data_noVC q [N][$];
  int            pops[$];
  int            seq = 0;

  // Behavioural model: link ownership expressed as plain integers.
  bit            m_locked;
  int            m_owner, m_ptr;
  bit            m_valid, m_err;
  flit_Data_noVC m_flit;
  logic [N-1:0]  cur_read;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(int k, flit_label_t l);
    flit_Data_noVC f;
    f.label = l;
    f.data  = 16'(k * 256 + seq);
    seq++;
    q[k].push_back(f);
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_valid = 0; m_err = 0; m_flit = '0;
  endtask

  function automatic logic [N-1:0] model_read();
    logic [N-1:0] r = '0;
    if (!rst_n || !down_on) return r;
    if (m_locked) begin
      if (q[m_owner].size() > 0) r[m_owner] = 1'b1;
    end else begin
      for (int off = 0; off < N; off++) begin
        int k = (m_ptr + off) % N;
        if (q[k].size() > 0) begin
          r[k] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      buf_empty[k] = (q[k].size() == 0);
      flit_i[k]    = (q[k].size() > 0) ? q[k][0] : '0;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    logic [N-1:0] exp_grant;
    cur_read  = model_read();
    exp_grant = m_locked ? (N'(1) << m_owner) : '0;
    check("read_o",       32'(read_o),       32'(cur_read));
    check("read_onehot",  32'($onehot0(read_o)), 32'd1);
    check("grant_o",      32'(grant_o),      32'(exp_grant));
    check("flit_valid_o", 32'(flit_valid_o), 32'(m_valid));
    check("proto_err_o",  32'(proto_err_o),  32'(m_err));
    check("flit_o",       32'(flit_o),       32'(m_flit));
    for (int k = 0; k < N; k++) if (read_o[k]) pops.push_back(k);
  endtask

  task automatic model_update();
    int k;
    flit_Data_noVC f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (cur_read == '0) begin
      m_valid = 0;
      return;
    end
    k = 0;
    for (int i = 0; i < N; i++) if (cur_read[i]) k = i;
    f = q[k].pop_front();
    m_flit  = f;
    m_valid = 1;
    if (!m_locked) begin
      if (f.label == HEAD) begin
        m_locked = 1;
        m_owner  = k;
      end else begin
        m_ptr = (k + 1) % N;
        m_err = (f.label == BODY) || (f.label == TAIL);
      end
    end else if (f.label == TAIL) begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % N;
    end else begin
      m_err = (f.label == HEAD) || (f.label == HEADTAIL);
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_inputs();
      #1;
      compare();
      @(posedge clk);
      model_update();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step(2);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive_inputs();
    do_reset();

    // Two single-flit packets on buffers 1 and 3.
    pops.delete();
    push(1, HEADTAIL); push(3, HEADTAIL);
    step(3);
    check("ht_pop_n", pops.size(), 2);
    check("ht_pop0",  pops[0], 1);
    check("ht_pop1",  pops[1], 3);
    check("ht_ptr",   m_ptr, 4);

    // Stray BODY while idle: forwarded, error pulse, pointer wraps to 0.
    pops.delete();
    push(4, BODY);
    step(1);
    #1;
    check("body_err",   32'(proto_err_o), 32'd1);
    check("body_valid", 32'(flit_valid_o), 32'd1);
    step(1);
    check("body_pop", pops[0], 4);
    check("body_ptr", m_ptr, 0);

    // Move the pointer to 1.
    push(0, HEADTAIL);
    step(2);
    check("ptr_one", m_ptr, 1);

    // Three-flit packet on 2 holds off buffer 0.
    pops.delete();
    push(2, HEAD); push(2, BODY); push(2, TAIL); push(0, HEADTAIL);
    step(3);
    check("pkt_ptr_after_tail", m_ptr, 3);
    step(2);
    check("pkt_pop_n", pops.size(), 4);
    check("pkt_pop0",  pops[0], 2);
    check("pkt_pop2",  pops[2], 2);
    check("pkt_pop3",  pops[3], 0);

    // Owner 2 stalled by downstream for 4 cycles.
    pops.delete();
    push(2, HEAD);
    step(2);
    push(2, BODY); push(2, TAIL);
    down_on = 1'b0;
    step(4);
    #1;
    check("stall_grant", 32'(grant_o), 32'h04);
    check("stall_pops",  pops.size(), 1);
    down_on = 1'b1;
    step(3);
    check("stall_pop_n", pops.size(), 3);
    check("stall_ptr",   m_ptr, 3);

    // Asynchronous reset in the middle of buffer 1's packet.
    pops.delete();
    push(1, HEAD); push(1, BODY);
    step(2);
    push(3, HEADTAIL);
    step(1);
    #1;
    check("pre_rst_grant", 32'(grant_o), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant_o), 32'h0);
    check("arst_valid", 32'(flit_valid_o), 32'd0);
    check("arst_err",   32'(proto_err_o), 32'd0);
    check("arst_flit",  32'(flit_o), 32'd0);
    check("arst_read",  32'(read_o), 32'h0);
    model_reset();
    step(1);
    #2 rst_n = 1'b1;
    pops.delete();
    step(1);
    push(1, TAIL);
    step(1);
    #1;
    check("late_tail_err", 32'(proto_err_o), 32'd1);
    step(1);
    check("rst_pop_n", pops.size(), 2);
    check("rst_pop0",  pops[0], 3);
    check("rst_pop1",  pops[1], 1);

    // All buffers busy with single-flit packets: strict rotation.
    do_reset();
    pops.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, HEADTAIL);
    step(11);
    check("rot_n", pops.size(), 10);
    for (int i = 0; i < 10; i++) check("rot_order", pops[i], i % N);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
